// File: rtl/dram_ras_control_pkg.sv
// Shared definitions for the VG8020 slot-3 DRAM row-side controller:
// state encodings, default timing constants and the registered output bundle.
package dram_ras_control_pkg;

  localparam int STATE_W        = 3;
  localparam int DEF_ROW_HOLD   = 1;
  localparam int DEF_PRECHARGE  = 2;
  localparam int DEF_RFSH_BITS  = 7;
  localparam int HOLD_W         = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_COL  = 3'd2,
    ST_RFSH = 3'd3,
    ST_PRE  = 3'd4
  } state_t;

  typedef struct packed {
    logic nras;
    logic mux;
    logic nmreqd;
    logic nwe;
    logic busy;
  } ras_out_t;

  localparam ras_out_t OUT_IDLE = '{nras: 1'b1, mux: 1'b0, nmreqd: 1'b1, nwe: 1'b1, busy: 1'b0};

  // A state lasting N cycles loads N-1 so the exit fires on the N-th edge.
  function automatic logic [HOLD_W-1:0] hold_preload(input int cycles);
    return HOLD_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dram_ras_control_if.sv
// Z80-side bus and DRAM-side strobes of the row controller.
// rfsh_row exists only when REFRESH_COUNTER_EN is defined.
interface dram_ras_control_if
`ifdef REFRESH_COUNTER_EN
  #(parameter int RFSH_BITS = 7)
`endif
  ;
  logic nmreq;
  logic nrfsh;
  logic nsltsl3;
  logic nrd;
  logic nwr;
  logic nras;
  logic mux;
  logic nmreqd;
  logic nwe;
  logic busy;
`ifdef REFRESH_COUNTER_EN
  logic [RFSH_BITS-1:0] rfsh_row;

  modport master (
    output nmreq, nrfsh, nsltsl3, nrd, nwr,
    input  nras, mux, nmreqd, nwe, busy, rfsh_row
  );

  modport slave (
    input  nmreq, nrfsh, nsltsl3, nrd, nwr,
    output nras, mux, nmreqd, nwe, busy, rfsh_row
  );
`else
  modport master (
    output nmreq, nrfsh, nsltsl3, nrd, nwr,
    input  nras, mux, nmreqd, nwe, busy
  );

  modport slave (
    input  nmreq, nrfsh, nsltsl3, nrd, nwr,
    output nras, mux, nmreqd, nwe, busy
  );
`endif

endinterface

// File: rtl/dram_hold_counter.sv
// 3-bit loadable down counter timing ROW and PRE residency.
// Saturates at zero rather than wrapping; zero flag is combinational.
module dram_hold_counter
  import dram_ras_control_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [HOLD_W-1:0] count_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/dram_ras_control.sv
// DRAM /RAS, row/column mux, early-write /WE and delayed /MREQ generator with RAS-only refresh.
// Optional macro REFRESH_COUNTER_EN adds an internal refresh row counter on rfsh_row.
module dram_ras_control
  import dram_ras_control_pkg::*;
#(
  parameter int ROW_HOLD  = DEF_ROW_HOLD,
  parameter int PRECHARGE = DEF_PRECHARGE
`ifdef REFRESH_COUNTER_EN
  ,
  parameter int RFSH_BITS = DEF_RFSH_BITS
`endif
) (
  input logic               clk,
  input logic               nreset,
  dram_ras_control_if.slave bus
);

  logic s_nmreq_reg;
  logic s_nrfsh_reg;
  logic s_nsltsl3_reg;
  logic s_nrd_reg;
  logic s_nwr_reg;
  logic prev_nmreq_reg;

  state_t   state_reg;
  state_t   state_next;
  ras_out_t out_reg;
  ras_out_t out_next;

  logic              hold_zero;
  logic              hold_load;
  logic [HOLD_W-1:0] hold_val;
  logic              mreq_fall;
  logic              write_req;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s_nmreq_reg    <= 1'b1;
      s_nrfsh_reg    <= 1'b1;
      s_nsltsl3_reg  <= 1'b1;
      s_nrd_reg      <= 1'b1;
      s_nwr_reg      <= 1'b1;
      prev_nmreq_reg <= 1'b1;
    end else begin
      s_nmreq_reg    <= bus.nmreq;
      s_nrfsh_reg    <= bus.nrfsh;
      s_nsltsl3_reg  <= bus.nsltsl3;
      s_nrd_reg      <= bus.nrd;
      s_nwr_reg      <= bus.nwr;
      prev_nmreq_reg <= s_nmreq_reg;
    end
  end

  // Only a genuine falling edge starts a cycle; /MREQ that went low during PRE is ignored.
  assign mreq_fall = prev_nmreq_reg & ~s_nmreq_reg;
  // /RD plays no part in /WE; /RD and /WR both low is still a write.
  assign write_req = ~s_nwr_reg | (~s_nrd_reg & ~s_nwr_reg);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= ST_IDLE;
      out_reg   <= OUT_IDLE;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (mreq_fall) begin
          if (!s_nrfsh_reg) begin
            state_next = ST_RFSH;
          end else if (!s_nsltsl3_reg) begin
            state_next = ST_ROW;
          end
        end
      end
      ST_ROW: begin
        if (s_nmreq_reg) begin
          state_next = ST_PRE;
        end else if (hold_zero) begin
          state_next = ST_COL;
        end
      end
      ST_COL:  if (s_nmreq_reg) state_next = ST_PRE;
      ST_RFSH: if (s_nmreq_reg) state_next = ST_PRE;
      ST_PRE:  if (hold_zero) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    out_next = '{nras: 1'b1, mux: 1'b0, nmreqd: 1'b1, nwe: 1'b1, busy: 1'b1};
    unique case (state_next)
      ST_IDLE: out_next.busy = 1'b0;
      ST_ROW:  out_next.nras = 1'b0;
      ST_COL: begin
        out_next.nras   = 1'b0;
        out_next.mux    = 1'b1;
        out_next.nmreqd = 1'b0;
        out_next.nwe    = ((state_reg == ST_COL) ? out_reg.nwe : 1'b1) & ~write_req;
      end
      ST_RFSH: out_next.nras = 1'b0;
      ST_PRE:  out_next.busy = 1'b1;
      default: out_next = OUT_IDLE;
    endcase
  end

  assign hold_load = (state_next != state_reg);
  assign hold_val  = (state_next == ST_ROW) ? hold_preload(ROW_HOLD) : hold_preload(PRECHARGE);

  dram_hold_counter u_hold (
    .clk      (clk),
    .nreset   (nreset),
    .load     (hold_load),
    .load_val (hold_val),
    .dec      (~hold_load),
    .zero     (hold_zero)
  );

  assign bus.nras   = out_reg.nras;
  assign bus.mux    = out_reg.mux;
  assign bus.nmreqd = out_reg.nmreqd;
  assign bus.nwe    = out_reg.nwe;
  assign bus.busy   = out_reg.busy;

`ifdef REFRESH_COUNTER_EN
  logic [RFSH_BITS-1:0] rfsh_row_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rfsh_row_reg <= '0;
    end else if ((state_reg == ST_RFSH) && (state_next == ST_PRE)) begin
      rfsh_row_reg <= rfsh_row_reg + 1'b1;
    end
  end

  assign bus.rfsh_row = rfsh_row_reg;
`endif

endmodule

// File: tb/tb_dram_ras_control.sv
// Directed bench for dram_ras_control: ROW_HOLD=1 instance for access/refresh/reset,
// ROW_HOLD=3 instance for the abort case.
module tb_dram_ras_control;

  logic clk;
  logic nreset;
  logic nmreq;
  logic nrfsh;
  logic nsltsl3;
  logic nrd;
  logic nwr;

  int total = 0;
  int bad   = 0;

  dram_ras_control_if bus1 ();
  dram_ras_control_if bus3 ();

  assign bus1.nmreq   = nmreq;
  assign bus1.nrfsh   = nrfsh;
  assign bus1.nsltsl3 = nsltsl3;
  assign bus1.nrd     = nrd;
  assign bus1.nwr     = nwr;
  assign bus3.nmreq   = nmreq;
  assign bus3.nrfsh   = nrfsh;
  assign bus3.nsltsl3 = nsltsl3;
  assign bus3.nrd     = nrd;
  assign bus3.nwr     = nwr;

  dram_ras_control #(.ROW_HOLD(1), .PRECHARGE(2)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus1)
  );

  dram_ras_control #(.ROW_HOLD(3), .PRECHARGE(2)) dut3 (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus3)
  );

  initial clk = 1'b0;
  always #35 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    nmreq = 1'b1; nrfsh = 1'b1; nsltsl3 = 1'b1; nrd = 1'b1; nwr = 1'b1;
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, "_nras"},   32'(bus1.nras),   32'd1);
    chk({tag, "_mux"},    32'(bus1.mux),    32'd0);
    chk({tag, "_nmreqd"}, 32'(bus1.nmreqd), 32'd1);
    chk({tag, "_nwe"},    32'(bus1.nwe),    32'd1);
    chk({tag, "_busy"},   32'(bus1.busy),   32'd0);
  endtask

`ifdef REFRESH_COUNTER_EN
  task automatic do_refresh();
    nmreq = 1'b0; nrfsh = 1'b0;
    repeat (3) tick();
    idle_inputs();
    repeat (4) tick();
  endtask
`endif

  initial begin
    idle_inputs();
    nreset = 1'b1;
    #3 nreset = 1'b0;
    #2;
    chk_idle1("rst");
    repeat (2) tick();
    chk_idle1("rst_hold");
    nreset = 1'b1;
    repeat (3) tick();
    chk_idle1("rst_rel");
    $display("tx reset");

    // Read from slot 3
    nmreq = 1'b0; nsltsl3 = 1'b0; nrd = 1'b0;
    tick(); chk("rd_e1_nras", 32'(bus1.nras), 32'd1);
    tick(); chk("rd_e2_nras", 32'(bus1.nras), 32'd0);
            chk("rd_e2_mux",  32'(bus1.mux),  32'd0);
            chk("rd_e2_busy", 32'(bus1.busy), 32'd1);
    tick(); chk("rd_e3_mux",  32'(bus1.mux),  32'd1);
            chk("rd_e3_nmreqd", 32'(bus1.nmreqd), 32'd0);
            chk("rd_e3_nwe",  32'(bus1.nwe),  32'd1);
    tick(); chk("rd_col_nras", 32'(bus1.nras), 32'd0);
    idle_inputs();
    tick(); chk("rd_x1_nras", 32'(bus1.nras), 32'd0);
    tick(); chk("rd_x2_nras", 32'(bus1.nras), 32'd1);
            chk("rd_x2_mux",  32'(bus1.mux),  32'd0);
            chk("rd_x2_nmreqd", 32'(bus1.nmreqd), 32'd1);
            chk("rd_x2_busy", 32'(bus1.busy), 32'd1);
    tick(); chk("rd_x3_busy", 32'(bus1.busy), 32'd1);
    tick(); chk("rd_x4_busy", 32'(bus1.busy), 32'd0);
    repeat (3) tick();
    $display("tx read");

    // Write with /WR low from the start; /WE must stay low even if /WR rises mid-COL
    nmreq = 1'b0; nsltsl3 = 1'b0; nwr = 1'b0;
    tick();
    tick(); chk("wr_e2_nwe", 32'(bus1.nwe), 32'd1);
    tick(); chk("wr_e3_nwe", 32'(bus1.nwe), 32'd0);
            chk("wr_e3_mux", 32'(bus1.mux), 32'd1);
    nwr = 1'b1;
    tick(); chk("wr_hold1_nwe", 32'(bus1.nwe), 32'd0);
    tick(); chk("wr_hold2_nwe", 32'(bus1.nwe), 32'd0);
    idle_inputs();
    tick(); chk("wr_x1_nwe", 32'(bus1.nwe), 32'd0);
    tick(); chk("wr_x2_nwe", 32'(bus1.nwe), 32'd1);
            chk("wr_x2_nras", 32'(bus1.nras), 32'd1);
    repeat (5) tick();
    $display("tx write");

    // Late write: /WR falls after COL entry
    nmreq = 1'b0; nsltsl3 = 1'b0;
    repeat (3) tick();
    chk("lw_col_nwe", 32'(bus1.nwe), 32'd1);
    nwr = 1'b0;
    tick(); chk("lw_l1_nwe", 32'(bus1.nwe), 32'd1);
    tick(); chk("lw_l2_nwe", 32'(bus1.nwe), 32'd0);
    idle_inputs();
    repeat (2) tick();
    chk("lw_x_nwe", 32'(bus1.nwe), 32'd1);
    repeat (5) tick();
    $display("tx late_write");

    // RAS-only refresh, refresh wins over slot select
    nmreq = 1'b0; nrfsh = 1'b0; nsltsl3 = 1'b0;
    tick(); chk("rf_e1_nras", 32'(bus1.nras), 32'd1);
    tick(); chk("rf_e2_nras", 32'(bus1.nras), 32'd0);
            chk("rf_e2_mux",  32'(bus1.mux),  32'd0);
            chk("rf_e2_nmreqd", 32'(bus1.nmreqd), 32'd1);
            chk("rf_e2_busy", 32'(bus1.busy), 32'd1);
    tick(); chk("rf_e3_mux",  32'(bus1.mux),  32'd0);
            chk("rf_e3_nmreqd", 32'(bus1.nmreqd), 32'd1);
    idle_inputs();
    tick(); chk("rf_x1_nras", 32'(bus1.nras), 32'd0);
    tick(); chk("rf_x2_nras", 32'(bus1.nras), 32'd1);
`ifdef REFRESH_COUNTER_EN
    chk("rf_row_1", 32'(bus1.rfsh_row), 32'd1);
`endif
    repeat (2) tick();
    chk("rf_x4_busy", 32'(bus1.busy), 32'd0);
`ifdef REFRESH_COUNTER_EN
    for (int i = 0; i < 127; i++) do_refresh();
    chk("rf_row_wrap", 32'(bus1.rfsh_row), 32'd0);
`endif
    repeat (3) tick();
    $display("tx refresh");

    // Other slot: nothing happens
    nmreq = 1'b0; nsltsl3 = 1'b1;
    repeat (3) tick();
    chk_idle1("oth");
    idle_inputs();
    repeat (3) tick();
    $display("tx other_slot");

    // Abort on ROW_HOLD=3 instance, then /MREQ low during PRE is ignored
    nmreq = 1'b0; nsltsl3 = 1'b0;
    tick();
    tick(); chk("ab_e2_nras", 32'(bus3.nras), 32'd0);
    nmreq = 1'b1;
    tick(); chk("ab_e3_nras", 32'(bus3.nras), 32'd0);
            chk("ab_e3_mux",  32'(bus3.mux),  32'd0);
            chk("ab_e3_nmreqd", 32'(bus3.nmreqd), 32'd1);
    tick(); chk("ab_e4_nras", 32'(bus3.nras), 32'd1);
            chk("ab_e4_nmreqd", 32'(bus3.nmreqd), 32'd1);
            chk("ab_e4_busy", 32'(bus3.busy), 32'd1);
    nmreq = 1'b0;
    tick(); chk("ab_e5_nras", 32'(bus3.nras), 32'd1);
    tick(); chk("ab_e6_busy", 32'(bus3.busy), 32'd0);
    tick(); chk("ab_e7_nras", 32'(bus3.nras), 32'd1);
    tick(); chk("ab_e8_nras", 32'(bus3.nras), 32'd1);
            chk("ab_e8_nmreqd", 32'(bus3.nmreqd), 32'd1);
            chk("ab_e8_busy", 32'(bus3.busy), 32'd0);
    idle_inputs();
    repeat (6) tick();
    $display("tx abort");

    // Asynchronous reset in the middle of COL
    nmreq = 1'b0; nsltsl3 = 1'b0; nwr = 1'b0;
    repeat (3) tick();
    chk("rc_col_mux", 32'(bus1.mux), 32'd1);
    #10 nreset = 1'b0;
    #1;
    chk_idle1("rc");
    idle_inputs();
    tick();
    nreset = 1'b1;
    repeat (2) tick();
    chk_idle1("rc_rel");
    nmreq = 1'b0; nsltsl3 = 1'b0;
    repeat (2) tick();
    chk("rc_new_nras", 32'(bus1.nras), 32'd0);
    idle_inputs();
    repeat (5) tick();
    $display("tx reset_mid_col");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
